// File: rtl/cip_mubi_obs_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cip_mubi_obs_pkg
//  Purpose  : Shared types and constants for the mubi observation tracker:
//             sample class enum, bin indices and the TRUE-pattern helper.
//  Options  : CIP_MUBI_OBS_STABLE_EN (used by cip_mubi_obs_chan)
//  Revision : 1.0  initial release
// ============================================================================
package cip_mubi_obs_pkg;

  // Classification of one mubi sample; NONE only exists before the first commit
  typedef enum logic [1:0] {
    NONE  = 2'd0,
    TRUE  = 2'd1,
    FALSE = 2'd2,
    INVAL = 2'd3
  } class_e;

  localparam int BinTrue  = 0;
  localparam int BinFalse = 1;
  localparam int BinInval = 2;
  localparam int BinT2f   = 3;
  localparam int BinF2t   = 4;
  localparam int NumBins  = 5;

  // TRUE pattern: nibbles 6,9,6,9... starting at the LSB, up to 16 bits wide
  function automatic logic [15:0] mubi_true_val(input int width);
    logic [15:0] val;
    val = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      if (i * 4 < width) begin
        val[i*4 +: 4] = (i % 2 == 0) ? 4'h6 : 4'h9;
      end
    end
    return val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cip_mubi_obs_chan.sv
`default_nettype none
// ============================================================================
//  Module   : cip_mubi_obs_chan
//  Purpose  : One mubi channel: classifier, previous-class register, sticky
//             bins, saturating invalid counter and invalid pulse.
//  Options  : CIP_MUBI_OBS_STABLE_EN - commit only values stable across two
//             enabled cycles (adds a raw-sample register)
//  Revision : 1.0  initial release
// ============================================================================
module cip_mubi_obs_chan
  import cip_mubi_obs_pkg::*;
#(
  parameter int Width    = 4,
  parameter int CntWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                clr_i,
  input  logic [Width-1:0]    mubi_i,
  output logic [NumBins-1:0]  bins_o,
  output logic [CntWidth-1:0] inval_cnt_o,
  output logic                inval_pulse_o
);

  localparam logic [15:0]         c_true_full = mubi_true_val(Width);
  localparam logic [Width-1:0]    c_true      = c_true_full[Width-1:0];
  localparam logic [CntWidth-1:0] c_cnt_one   = {{(CntWidth-1){1'b0}}, 1'b1};

  class_e                r_prev;
  logic [NumBins-1:0]    r_bins;
  logic [CntWidth-1:0]   r_cnt;
  logic                  r_pulse;

  class_e                w_cur;
  logic [NumBins-1:0]    w_bins_nxt;
  logic                  w_stable;
  logic                  w_commit;

  // Classify the current sample against the TRUE pattern and its inverse
  always_comb begin
    w_cur = INVAL;
    if (mubi_i == c_true) begin
      w_cur = TRUE;
    end else if (mubi_i == ~c_true) begin
      w_cur = FALSE;
    end
  end

`ifdef CIP_MUBI_OBS_STABLE_EN
  logic [Width-1:0] r_raw;

  // Capture the raw sample on every enabled cycle for the stability compare
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_raw <= '0;
    end else if (clr_i) begin
      r_raw <= '0;
    end else if (en_i) begin
      r_raw <= mubi_i;
    end
  end

  assign w_stable = (mubi_i == r_raw);
`else
  assign w_stable = 1'b1;
`endif

  assign w_commit = en_i & ~clr_i & w_stable;

  // Next sticky bins: class bin plus a transition bin only on a direct TRUE<->FALSE
  always_comb begin
    w_bins_nxt = r_bins;
    case (w_cur)
      TRUE: begin
        w_bins_nxt[BinTrue] = 1'b1;
        if (r_prev == FALSE) w_bins_nxt[BinF2t] = 1'b1;
      end
      FALSE: begin
        w_bins_nxt[BinFalse] = 1'b1;
        if (r_prev == TRUE) w_bins_nxt[BinT2f] = 1'b1;
      end
      default: begin
        w_bins_nxt[BinInval] = 1'b1;
      end
    endcase
  end

  // Channel state: clear wins over enable; pulse only lives for one cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_prev  <= NONE;
      r_bins  <= '0;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else if (clr_i) begin
      r_prev  <= NONE;
      r_bins  <= '0;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= w_commit && (w_cur == INVAL);
      if (w_commit) begin
        r_bins <= w_bins_nxt;
        r_prev <= w_cur;
        if ((w_cur == INVAL) && (r_cnt != {CntWidth{1'b1}})) begin
          r_cnt <= r_cnt + c_cnt_one;
        end
      end
    end
  end

  assign bins_o        = r_bins;
  assign inval_cnt_o   = r_cnt;
  assign inval_pulse_o = r_pulse;

endmodule
`default_nettype wire

// File: rtl/cip_mubi_obs_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : cip_mubi_obs_tracker
//  Purpose  : Observes a packed array of mubi signals, records per-channel
//             coverage bins and invalid counts, and flags full coverage.
//  Options  : CIP_MUBI_OBS_STABLE_EN - glitch rejection in each channel
//  Revision : 1.0  initial release
// ============================================================================
module cip_mubi_obs_tracker
  import cip_mubi_obs_pkg::*;
#(
  parameter int NumMubis = 1,
  parameter int Width    = 4,
  parameter int CntWidth = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  input  logic                         clr_i,
  input  logic [NumMubis*Width-1:0]    mubis_i,
  output logic [NumMubis*NumBins-1:0]  bins_o,
  output logic [NumMubis*CntWidth-1:0] inval_cnt_o,
  output logic [NumMubis-1:0]          inval_pulse_o,
  output logic                         all_covered_o
);

  logic [NumMubis*NumBins-1:0] w_bins;
  logic                        r_all;

  for (genvar k = 0; k < NumMubis; k++) begin : g_chan
    cip_mubi_obs_chan #(
      .Width    (Width),
      .CntWidth (CntWidth)
    ) u_chan (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .en_i          (en_i),
      .clr_i         (clr_i),
      .mubi_i        (mubis_i[k*Width +: Width]),
      .bins_o        (w_bins[k*NumBins +: NumBins]),
      .inval_cnt_o   (inval_cnt_o[k*CntWidth +: CntWidth]),
      .inval_pulse_o (inval_pulse_o[k])
    );
  end

  // Coverage flag follows the registered bins by one cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_all <= 1'b0;
    end else if (clr_i) begin
      r_all <= 1'b0;
    end else begin
      r_all <= &w_bins;
    end
  end

  assign bins_o        = w_bins;
  assign all_covered_o = r_all;

endmodule
`default_nettype wire

// File: tb/tb_cip_mubi_obs_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cip_mubi_obs_tracker
//  Purpose  : Randomized self-checking bench for cip_mubi_obs_tracker with a
//             behavioural reference model; two configurations in parallel.
//  Options  : CIP_MUBI_OBS_STABLE_EN - model follows the RTL build
//  Revision : 1.0  initial release
// ============================================================================
module tb_cip_mubi_obs_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        clr;
  logic [15:0] mubis_a;
  logic [15:0] mubis_b;

  logic [9:0]  bins_a;
  logic [3:0]  cnt_a;
  logic [1:0]  pulse_a;
  logic        all_a;
  logic [4:0]  bins_b;
  logic [2:0]  cnt_b;
  logic [0:0]  pulse_b;
  logic        all_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Config A: two 8-bit channels, 2-bit counters (saturates at 3)
  cip_mubi_obs_tracker #(.NumMubis(2), .Width(8), .CntWidth(2)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .mubis_i(mubis_a),
    .bins_o(bins_a), .inval_cnt_o(cnt_a), .inval_pulse_o(pulse_a),
    .all_covered_o(all_a)
  );

  // Config B: one 16-bit channel, 3-bit counter (saturates at 7)
  cip_mubi_obs_tracker #(.NumMubis(1), .Width(16), .CntWidth(3)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .mubis_i(mubis_b),
    .bins_o(bins_b), .inval_cnt_o(cnt_b), .inval_pulse_o(pulse_b),
    .all_covered_o(all_b)
  );

  // Reference model state; channels 0,1 belong to A, channel 2 to B.
  // prev: 0 none, 1 true, 2 false, 3 invalid
  int          m_prev [3];
  logic [4:0]  m_bins [3];
  int          m_cnt  [3];
  logic        m_pulse[3];
  logic [15:0] m_raw  [3];
  logic        m_all  [2];
  logic [15:0] cur_val[3];

  function automatic int chan_width(input int ch);
    return (ch == 2) ? 16 : 8;
  endfunction

  function automatic int chan_max(input int ch);
    return (ch == 2) ? 7 : 3;
  endfunction

  function automatic logic [15:0] width_mask(input int w);
    return (w == 16) ? 16'hFFFF : ((16'h1 << w) - 16'h1);
  endfunction

  function automatic logic [15:0] true_pat(input int w);
    logic [15:0] tv;
    tv = 16'h0;
    for (int n = 0; n < w / 4; n++) begin
      tv = tv | (((n % 2 == 0) ? 16'h6 : 16'h9) << (4 * n));
    end
    return tv;
  endfunction

  function automatic int classify(input logic [15:0] v, input int w);
    logic [15:0] tv;
    tv = true_pat(w);
    if (v == tv) return 1;
    if (v == (~tv & width_mask(w))) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_prev[c] = 0; m_bins[c] = '0; m_cnt[c] = 0; m_pulse[c] = 1'b0; m_raw[c] = '0;
    end
    m_all[0] = 1'b0;
    m_all[1] = 1'b0;
  endtask

  task automatic model_step(input logic e, input logic c_in);
    logic nxt_all0, nxt_all1;
    nxt_all0 = &{m_bins[0], m_bins[1]};
    nxt_all1 = &m_bins[2];
    for (int c = 0; c < 3; c++) begin
      if (c_in) begin
        m_prev[c] = 0; m_bins[c] = '0; m_cnt[c] = 0; m_pulse[c] = 1'b0; m_raw[c] = '0;
      end else if (e) begin
        int   cls;
        logic commit;
        cls = classify(cur_val[c], chan_width(c));
`ifdef CIP_MUBI_OBS_STABLE_EN
        commit = (cur_val[c] == m_raw[c]);
`else
        commit = 1'b1;
`endif
        m_raw[c]   = cur_val[c];
        m_pulse[c] = commit && (cls == 3);
        if (commit) begin
          m_bins[c][cls-1] = 1'b1;
          if (m_prev[c] == 1 && cls == 2) m_bins[c][3] = 1'b1;
          if (m_prev[c] == 2 && cls == 1) m_bins[c][4] = 1'b1;
          m_prev[c] = cls;
          if (cls == 3 && m_cnt[c] < chan_max(c)) m_cnt[c] = m_cnt[c] + 1;
        end
      end else begin
        m_pulse[c] = 1'b0;
      end
    end
    m_all[0] = c_in ? 1'b0 : nxt_all0;
    m_all[1] = c_in ? 1'b0 : nxt_all1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [1:0] c0, c1;
    logic [2:0] c2;
    c0 = m_cnt[0][1:0];
    c1 = m_cnt[1][1:0];
    c2 = m_cnt[2][2:0];
    check_eq("bins_a",  32'(bins_a),  32'({m_bins[1], m_bins[0]}));
    check_eq("cnt_a",   32'(cnt_a),   32'({c1, c0}));
    check_eq("pulse_a", 32'(pulse_a), 32'({m_pulse[1], m_pulse[0]}));
    check_eq("all_a",   32'(all_a),   32'(m_all[0]));
    check_eq("bins_b",  32'(bins_b),  32'(m_bins[2]));
    check_eq("cnt_b",   32'(cnt_b),   32'(c2));
    check_eq("pulse_b", 32'(pulse_b), 32'(m_pulse[2]));
    check_eq("all_b",   32'(all_b),   32'(m_all[1]));
  endtask

  // Mostly valid values, some invalid; often held so stable commits happen
  function automatic logic [15:0] gen_val(input int w, input logic [15:0] prev);
    int r;
    if ($urandom_range(0, 9) < 4) return prev;
    r = $urandom_range(0, 9);
    if (r < 4) return true_pat(w);
    if (r < 8) return ~true_pat(w) & width_mask(w);
    if (r == 8) return 16'($urandom) & width_mask(w);
    return 16'h0;
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; mubis_a = '0; mubis_b = '0;
    for (int c = 0; c < 3; c++) cur_val[c] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_outputs();
    @(negedge clk);
    rst = 1'b0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      en  = ($urandom_range(0, 9) < 8);
      clr = ($urandom_range(0, 59) == 0);
      for (int c = 0; c < 3; c++) cur_val[c] = gen_val(chan_width(c), cur_val[c]);
      mubis_a = {cur_val[1][7:0], cur_val[0][7:0]};
      mubis_b = cur_val[2];
      @(posedge clk);
      model_step(en, clr);
      #1 check_outputs();
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1'b1;
        model_reset();
        #1 check_outputs();
      end
      @(negedge clk);
      rst = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cip_mubi_obs_tracker.md
Name: cip_mubi_obs_tracker

Overview:
- Downstream consumer of a packed array of multi-bit-boolean (mubi) signals, the same array a block binds for mubi coverage.
- Classifies each mubi every enabled cycle as TRUE, FALSE or INVALID.
- Records per-channel bins: seen-true, seen-false, seen-invalid, true->false, false->true.
- Keeps a saturating invalid-sample counter per channel and raises all_covered_o once every channel has hit every bin.

Parameters:
- NumMubis, 1, number of mubi channels observed.
- Width, 4, bits per mubi; multiple of 4, range 4..16.
- CntWidth, 8, width of each per-channel invalid counter.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset.
- en_i  input  1  sample enable; no state changes when low.
- clr_i  input  1  synchronous clear of bins, counters and previous class.
- mubis_i  input  NumMubis*Width  packed mubi array; channel k is bits [k*Width +: Width].
- bins_o  output  NumMubis*5  per-channel sticky bins {f2t, t2f, inval, false, true}, with true at the LSB.
- inval_cnt_o  output  NumMubis*CntWidth  per-channel saturating invalid count.
- inval_pulse_o  output  NumMubis  one-cycle flag: channel's committed sample was INVALID.
- all_covered_o  output  1  AND of all bins across all channels.

Behaviour:
- Interface (already decided): one clock, clk_i; reset rst_i is asynchronous and active-high.
- Reset values:
  - All outputs are 0.
  - Each channel's prev_class is NONE.
  - Each channel's raw-sample register is 0.
- Encoding:
  - TRUE value is nibbles alternating from the LSB: 4'h6, 4'h9, 4'h6, ... (Width 4 -> 'h6, 8 -> 'h96, 12 -> 'h696, 16 -> 'h9696).
  - FALSE is the bitwise inverse of TRUE.
  - Any other value is INVALID.
- Commit on a cycle with en_i=1, clr_i=0 and a valid commit condition (see Optional Feature), from the classification cur:
  - Set the bin matching cur.
  - If prev_class is TRUE and cur is FALSE, set t2f.
  - If prev_class is FALSE and cur is TRUE, set f2t.
  - prev_class <= cur.
  - If cur is INVALID: inval_cnt += 1, saturating at 2^CntWidth-1, and inval_pulse_o=1 for the following cycle.
- Latency: outputs reflect a sample one cycle after the sampling edge.
- en_i=0: all state holds; inval_pulse_o is 0.
- clr_i=1:
  - Bins, counters, pulses and raw registers go to 0; prev_class goes to NONE.
  - clr_i has priority over en_i in the same cycle.
  - The sample in that cycle is discarded.
- Transitions through INVALID do not count: TRUE -> INVALID -> FALSE sets no t2f, because prev_class is INVALID when FALSE arrives.
- Repeated same class: bins are sticky and no transition bin is set.
- all_covered_o is registered and is the AND of all NumMubis*5 bin bits. It deasserts on clr_i or reset.
- Asynchronous reset mid-operation clears everything immediately. The first post-reset sample has prev_class NONE, so no transition bin is set.

Optional Feature:
- Macro: CIP_MUBI_OBS_STABLE_EN.
- Defined:
  - A sample commits only if mubis_i for that channel equals the raw value captured at the previous enabled cycle. This rejects single-cycle glitches.
  - The raw register updates on every enabled cycle.
  - Commit latency from a value change is 2 enabled cycles.
- Undefined: every enabled sample commits and no raw register is instantiated.

Decomposition:
- Package cip_mubi_obs_pkg contains:
  - the class enum, class_e: NONE, TRUE, FALSE, INVAL (2 bits);
  - bin index constants: BinTrue=0, BinFalse=1, BinInval=2, BinT2f=3, BinF2t=4, NumBins=5;
  - function mubi_true_val(width), returning the TRUE pattern.
- Sub-module cip_mubi_obs_chan handles one channel: classifier, prev_class register, bins, counter, pulse, optional raw register.
- The top level instantiates one cip_mubi_obs_chan per channel in a generate loop and forms all_covered_o.

Test Plan:
- Width=4, NumMubis=1, en_i=1, feature undefined; drive 'h6, 'h9, 'h6 on consecutive cycles -> bins_o = 5'b11011 after the third sample; inval_cnt_o=0; all_covered_o=0.
- Continue with 'h3 -> bins_o = 5'b11111, inval_pulse_o=1 for one cycle, inval_cnt_o=1; all_covered_o=1 the following cycle.
- CntWidth=2; drive 'h0 for 5 enabled cycles -> inval_cnt_o saturates at 3; inval_pulse_o stays high for 5 cycles.
- Drive 'h6, 'hA, 'h9 -> t2f stays 0; bins true, false and inval are set.
- Drive 'h6 with en_i=0 -> bins_o unchanged; then assert clr_i and en_i together with 'h9 -> all outputs 0, and the next cycle still shows bins 0.
- Feature defined, Width=8; drive 'h96 for 1 cycle between 'h69 runs -> true bin never set; drive 'h96 for 2 cycles -> true bin set 2 cycles after the first 'h96.
